sc_timer_backg: RTL and testbench
=================================

# sc_timer_backg

Dual terminal-count timer that sits next to the background-lane state machine, the controller that sequences the Frogger background shift register. It counts the controller's active-low count-enable pulses and returns the two active-low expiry flags, T0 (lane shift) and T1 (display refresh). Each flag is held until the controller consumes it, so no expiry is lost while the controller is in another branch.

## Interface
Parameters:
- `T0_LIMIT`, default 25_000, number of `upcount` pulses per lane-shift period.
- `T1_LIMIT`, default 5_000, number of `upcount2` pulses per display period.
- `CNT_W`, default 16, counter width; must satisfy `2^CNT_W > max(T0_LIMIT, T1_LIMIT)`.
- `T0_MIN`, default 5_000, floor for the speed-up limit. Used only with `SC_TIMERBACKG_SPEEDUP_EN`.
- `T0_STEP`, default 1_000, limit decrement per lane shift. Used only with `SC_TIMERBACKG_SPEEDUP_EN`.

Ports:
- `SC_TIMERBACKG_CLOCK_50`, in, 1, system clock. This is the single clock; all logic is on its rising edge.
- `SC_TIMERBACKG_RESET_InLow`, in, 1, reset, synchronous, active-low.
- `SC_TIMERBACKG_clear_InLow`, in, 1, synchronous clear from the controller, active-low.
- `SC_TIMERBACKG_upcount_InLow`, in, 1, T0 channel count enable, active-low.
- `SC_TIMERBACKG_upcount2_InLow`, in, 1, T1 channel count enable, active-low.
- `SC_TIMERBACKG_T0_OutLow`, out, 1, lane-shift expiry flag, active-low, registered.
- `SC_TIMERBACKG_T1_OutLow`, out, 1, display expiry flag, active-low, registered.
- `SC_TIMERBACKG_limit_Out`, out, CNT_W, current T0 limit, for debug and score logic.

## Operation
- The block has two identical channels, n ∈ {0,1}. Each channel has a counter `cnt_n` and a two-state FSM:
  - RUN: flag high.
  - EXPIRED: flag low.
- RUN state:
  - An enable low with `cnt_n == LIMIT_n-1` sets `cnt_n` to 0 and moves to EXPIRED.
  - Any other enable low increments `cnt_n`.
  - Enable high holds `cnt_n`.
- EXPIRED state:
  - The counter is frozen at 0.
  - The first enable low while in EXPIRED is the consume event. It returns the channel to RUN and does not increment the counter.
  - Enable high stays in EXPIRED indefinitely.
- `clear_InLow` low:
  - Both channels go to RUN with `cnt = 0`.
  - The T0 limit reloads to `T0_LIMIT`.
  - Clear has priority over the enables.
- Reset low has the same effect as clear and has the highest priority.
- The two channels are independent. Simultaneous enables on both channels are processed in parallel in the same cycle.
- Each period therefore spans exactly LIMIT enable pulses from the consume event (or clear) to the next expiry.
- `LIMIT_n` of 0 or 1 is illegal; an assertion fires on elaboration.

## Timing
- Reset values:
  - `T0_OutLow = 1`, `T1_OutLow = 1`.
  - Counters = 0.
  - `limit_Out = T0_LIMIT`.
- Flag latency: the flag goes low on the clock edge that samples the LIMIT-th enable pulse, which is 1 cycle after that enable is presented.
- Consume latency: the flag returns high on the edge that samples the consume enable.
- Enables are level-sampled every clock. A 1-cycle pulse from the controller counts once; a held-low enable counts once per cycle.
- Reset asserted mid-count or while EXPIRED: the flags are high on the next edge and no partial count survives.
- Clear asserted on the same edge as the terminal enable: clear wins and the flag stays high.

## Configuration
- Macro: `SC_TIMERBACKG_SPEEDUP_EN`.
- Defined:
  - Each T0 expiry reduces the T0 limit by `T0_STEP`, saturating at `T0_MIN`.
  - The new limit applies from the next period.
  - Clear and reset restore `T0_LIMIT`.
- Undefined: the T0 limit is constant at `T0_LIMIT`, and `limit_Out` is tied to `T0_LIMIT`.

## Structure
- Package `sc_timerbackg_pkg` holds:
  - the channel state enum (RUN, EXPIRED);
  - the default limit constants.
- One sub-module, `sc_timer_channel`, implements the counter plus two-state FSM with a runtime `limit` input. It is instantiated twice.
- The speed-up limit register lives in the top level.

## Test plan
- Reset: hold reset low for 3 cycles with the enables low. Both flags stay 1, `limit_Out = 25000`, and the counters are 0 after release.
- T0 expiry (`T0_LIMIT = 4`): 4 single-cycle upcount pulses spaced 2 cycles apart. `T0_OutLow` goes 0 one cycle after the 4th pulse and stays 0 for 20 idle cycles. The next pulse returns it to 1, and 4 further pulses are needed for the next expiry.
- Channel independence (`T0_LIMIT = 4`, `T1_LIMIT = 3`): assert both enables continuously. T1 flags after 3 cycles and T0 after 4, with no cross-coupling.
- Clear priority: assert clear on the same edge as the 4th T0 pulse. The flag stays 1 and the counter is 0, so 4 new pulses are needed.
- Speed-up, macro defined (`T0_LIMIT = 6`, `T0_STEP = 2`, `T0_MIN = 3`):
  - The limit goes 6 → 4 → 3 → 3 over successive expiries.
  - Expiries occur after 6, 4 and 3 pulses respectively.
  - A clear restores the limit to 6.
- Mid-operation reset: reset at count 2 of 4. After release, 4 full pulses are required, and the flags are high during reset.

Source files
------------

// File: rtl/sc_timerbackg_pkg.sv
// Shared types and default limits for the background-lane dual timer.
package sc_timerbackg_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        EXPIRED = 1'b1
    } chanState_t;

    localparam int T0_LIMIT_DEF = 25000;
    localparam int T1_LIMIT_DEF = 5000;
    localparam int CNT_W_DEF    = 16;
    localparam int T0_MIN_DEF   = 5000;
    localparam int T0_STEP_DEF  = 1000;

endpackage

// File: rtl/sc_timer_channel.sv
// One terminal-count channel: counter plus RUN/EXPIRED FSM with a held, active-low expiry flag.
module sc_timer_channel
    import sc_timerbackg_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             resetInLow,
    input  logic             clearInLow,
    input  logic             enableInLow,
    input  logic [CNT_W-1:0] limit,
    output logic             flagOutLow
);

    chanState_t       state;
    logic [CNT_W-1:0] cnt;

    // Counter and state update; the first enable seen while EXPIRED is the consume event.
    always_ff @(posedge clk) begin
        if (!resetInLow || !clearInLow) begin
            state      <= RUN;
            cnt        <= {CNT_W{1'b0}};
            flagOutLow <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (!enableInLow) begin
                        if (cnt == limit - CNT_W'(1)) begin
                            cnt        <= {CNT_W{1'b0}};
                            state      <= EXPIRED;
                            flagOutLow <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                EXPIRED: begin
                    cnt <= {CNT_W{1'b0}};
                    if (!enableInLow) begin
                        state      <= RUN;
                        flagOutLow <= 1'b1;
                    end
                end
                default: begin
                    state      <= RUN;
                    cnt        <= {CNT_W{1'b0}};
                    flagOutLow <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/sc_timer_backg.sv
// Dual terminal-count timer (lane shift T0, display refresh T1) for the background-lane controller.
// Optional feature: define SC_TIMERBACKG_SPEEDUP_EN to shorten the T0 period on every lane shift.
module sc_timer_backg
    import sc_timerbackg_pkg::*;
#(
    parameter int T0_LIMIT = T0_LIMIT_DEF,
    parameter int T1_LIMIT = T1_LIMIT_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int T0_MIN   = T0_MIN_DEF,
    parameter int T0_STEP  = T0_STEP_DEF
) (
    input  logic             SC_TIMERBACKG_CLOCK_50,
    input  logic             SC_TIMERBACKG_RESET_InLow,
    input  logic             SC_TIMERBACKG_clear_InLow,
    input  logic             SC_TIMERBACKG_upcount_InLow,
    input  logic             SC_TIMERBACKG_upcount2_InLow,
    output logic             SC_TIMERBACKG_T0_OutLow,
    output logic             SC_TIMERBACKG_T1_OutLow,
    output logic [CNT_W-1:0] SC_TIMERBACKG_limit_Out
);

    // A limit below 2 can never produce a distinct period; the speed-up floor obeys the same rule.
    if (T0_LIMIT < 2 || T1_LIMIT < 2 || T0_MIN < 2 || T0_MIN > T0_LIMIT || T0_STEP < 1) begin : gBadLimit
        $error("sc_timer_backg: illegal limit parameters");
    end

    logic [CNT_W-1:0] t0Limit;

`ifdef SC_TIMERBACKG_SPEEDUP_EN
    logic t0FlagPrev;

    // Expiry is seen as the falling edge of the T0 flag; the new limit lands before the next period counts.
    always_ff @(posedge SC_TIMERBACKG_CLOCK_50) begin
        if (!SC_TIMERBACKG_RESET_InLow || !SC_TIMERBACKG_clear_InLow) begin
            t0Limit    <= CNT_W'(T0_LIMIT);
            t0FlagPrev <= 1'b1;
        end else begin
            t0FlagPrev <= SC_TIMERBACKG_T0_OutLow;
            if (t0FlagPrev && !SC_TIMERBACKG_T0_OutLow) begin
                if (t0Limit >= CNT_W'(T0_MIN + T0_STEP)) begin
                    t0Limit <= t0Limit - CNT_W'(T0_STEP);
                end else begin
                    t0Limit <= CNT_W'(T0_MIN);
                end
            end
        end
    end
`else
    assign t0Limit = CNT_W'(T0_LIMIT);
`endif

    assign SC_TIMERBACKG_limit_Out = t0Limit;

    sc_timer_channel #(.CNT_W(CNT_W)) uChanT0 (
        .clk         (SC_TIMERBACKG_CLOCK_50),
        .resetInLow  (SC_TIMERBACKG_RESET_InLow),
        .clearInLow  (SC_TIMERBACKG_clear_InLow),
        .enableInLow (SC_TIMERBACKG_upcount_InLow),
        .limit       (t0Limit),
        .flagOutLow  (SC_TIMERBACKG_T0_OutLow)
    );

    sc_timer_channel #(.CNT_W(CNT_W)) uChanT1 (
        .clk         (SC_TIMERBACKG_CLOCK_50),
        .resetInLow  (SC_TIMERBACKG_RESET_InLow),
        .clearInLow  (SC_TIMERBACKG_clear_InLow),
        .enableInLow (SC_TIMERBACKG_upcount2_InLow),
        .limit       (CNT_W'(T1_LIMIT)),
        .flagOutLow  (SC_TIMERBACKG_T1_OutLow)
    );

endmodule

// File: tb/tb_sc_timer_backg.sv
// Directed self-checking bench for sc_timer_backg (small limits; speed-up checks when SC_TIMERBACKG_SPEEDUP_EN is defined).
module tb_sc_timer_backg;

`ifdef SC_TIMERBACKG_SPEEDUP_EN
    localparam int T0L = 6;
`else
    localparam int T0L = 4;
`endif
    localparam int T1L   = 3;
    localparam int CW    = 16;
    localparam int TMIN  = 3;
    localparam int TSTEP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_n = 1'b1;
    logic          up_n = 1'b1;
    logic          up2_n = 1'b1;
    logic          t0_n;
    logic          t1_n;
    logic [CW-1:0] limit;

    int n_compared = 0;
    int n_mismatch = 0;

    sc_timer_backg #(
        .T0_LIMIT (T0L),
        .T1_LIMIT (T1L),
        .CNT_W    (CW),
        .T0_MIN   (TMIN),
        .T0_STEP  (TSTEP)
    ) dut (
        .SC_TIMERBACKG_CLOCK_50       (clk),
        .SC_TIMERBACKG_RESET_InLow    (rst_n),
        .SC_TIMERBACKG_clear_InLow    (clr_n),
        .SC_TIMERBACKG_upcount_InLow  (up_n),
        .SC_TIMERBACKG_upcount2_InLow (up2_n),
        .SC_TIMERBACKG_T0_OutLow      (t0_n),
        .SC_TIMERBACKG_T1_OutLow      (t1_n),
        .SC_TIMERBACKG_limit_Out      (limit)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_t0();
        up_n = 1'b0;
        tick();
        up_n = 1'b1;
    endtask

    task automatic do_clear();
        clr_n = 1'b0;
        tick();
        clr_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; up_n = 1'b0; up2_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++;
            if (t0_n !== 1'b1 || t1_n !== 1'b1) begin
                n_mismatch++;
                $display("FAIL reset_flags cyc%0d: got T0=%b T1=%b expected 1 1", i, t0_n, t1_n);
            end
            n_compared++;
            if (limit !== CW'(T0L)) begin
                n_mismatch++;
                $display("FAIL reset_limit: got %0d expected %0d", limit, T0L);
            end
        end
        rst_n = 1'b1; up_n = 1'b1; up2_n = 1'b1;
        tick();
        for (int i = 0; i < T0L - 1; i++) pulse_t0();
        n_compared++;
        if (t0_n !== 1'b1) begin
            n_mismatch++;
            $display("FAIL reset_cnt_zero_pre: got %b expected 1", t0_n);
        end
        pulse_t0();
        n_compared++;
        if (t0_n !== 1'b0) begin
            n_mismatch++;
            $display("FAIL reset_cnt_zero_exp: got %b expected 0", t0_n);
        end
    endtask

    task automatic test_t0_expiry();
        do_clear();
        for (int p = 1; p <= T0L; p++) begin
            pulse_t0();
            n_compared++;
            if (t0_n !== ((p == T0L) ? 1'b0 : 1'b1)) begin
                n_mismatch++;
                $display("FAIL t0_pulse%0d: got %b expected %b", p, t0_n, (p == T0L) ? 1'b0 : 1'b1);
            end
            if (p != T0L) tick();
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            n_compared++;
            if (t0_n !== 1'b0) begin
                n_mismatch++;
                $display("FAIL t0_hold idle%0d: got %b expected 0", i, t0_n);
            end
        end
`ifndef SC_TIMERBACKG_SPEEDUP_EN
        n_compared++;
        if (limit !== CW'(T0L)) begin
            n_mismatch++;
            $display("FAIL t0_limit_const: got %0d expected %0d", limit, T0L);
        end
`endif
        pulse_t0();
        n_compared++;
        if (t0_n !== 1'b1) begin
            n_mismatch++;
            $display("FAIL t0_consume: got %b expected 1", t0_n);
        end
        do_clear();
        for (int p = 1; p <= T0L; p++) begin
            pulse_t0();
            tick();
            n_compared++;
            if (t0_n !== ((p == T0L) ? 1'b0 : 1'b1)) begin
                n_mismatch++;
                $display("FAIL t0_second%0d: got %b expected %b", p, t0_n, (p == T0L) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_independence();
        do_clear();
        up_n = 1'b0; up2_n = 1'b0;
        for (int k = 1; k <= T0L; k++) begin
            tick();
            n_compared++;
            if (t0_n !== ((k == T0L) ? 1'b0 : 1'b1)) begin
                n_mismatch++;
                $display("FAIL indep_t0 k%0d: got %b expected %b", k, t0_n, (k == T0L) ? 1'b0 : 1'b1);
            end
            n_compared++;
            if (t1_n !== ((k % 4 == 3) ? 1'b0 : 1'b1)) begin
                n_mismatch++;
                $display("FAIL indep_t1 k%0d: got %b expected %b", k, t1_n, (k % 4 == 3) ? 1'b0 : 1'b1);
            end
        end
        up_n = 1'b1; up2_n = 1'b1;
        tick();
    endtask

    task automatic test_clear_priority();
        do_clear();
        for (int i = 0; i < T0L - 1; i++) pulse_t0();
        up_n = 1'b0; clr_n = 1'b0;
        tick();
        up_n = 1'b1; clr_n = 1'b1;
        n_compared++;
        if (t0_n !== 1'b1) begin
            n_mismatch++;
            $display("FAIL clear_wins: got %b expected 1", t0_n);
        end
        tick();
        n_compared++;
        if (limit !== CW'(T0L)) begin
            n_mismatch++;
            $display("FAIL clear_limit: got %0d expected %0d", limit, T0L);
        end
        for (int i = 0; i < T0L - 1; i++) pulse_t0();
        n_compared++;
        if (t0_n !== 1'b1) begin
            n_mismatch++;
            $display("FAIL clear_recount_pre: got %b expected 1", t0_n);
        end
        pulse_t0();
        n_compared++;
        if (t0_n !== 1'b0) begin
            n_mismatch++;
            $display("FAIL clear_recount_exp: got %b expected 0", t0_n);
        end
    endtask

    task automatic test_mid_reset();
        do_clear();
        pulse_t0();
        pulse_t0();
        rst_n = 1'b0; up_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_compared++;
            if (t0_n !== 1'b1 || t1_n !== 1'b1) begin
                n_mismatch++;
                $display("FAIL midrst_flags cyc%0d: got T0=%b T1=%b expected 1 1", i, t0_n, t1_n);
            end
        end
        rst_n = 1'b1; up_n = 1'b1;
        tick();
        for (int i = 0; i < T0L - 1; i++) pulse_t0();
        n_compared++;
        if (t0_n !== 1'b1) begin
            n_mismatch++;
            $display("FAIL midrst_pre: got %b expected 1", t0_n);
        end
        pulse_t0();
        n_compared++;
        if (t0_n !== 1'b0) begin
            n_mismatch++;
            $display("FAIL midrst_exp: got %b expected 0", t0_n);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_compared++;
        if (t0_n !== 1'b1) begin
            n_mismatch++;
            $display("FAIL rst_while_expired: got %b expected 1", t0_n);
        end
    endtask

`ifdef SC_TIMERBACKG_SPEEDUP_EN
    task automatic test_speedup();
        int lims [4];
        int nexts [4];
        lims  = '{6, 4, 3, 3};
        nexts = '{4, 3, 3, 3};
        do_clear();
        for (int e = 0; e < 4; e++) begin
            n_compared++;
            if (limit !== CW'(lims[e])) begin
                n_mismatch++;
                $display("FAIL spd_limit%0d: got %0d expected %0d", e, limit, lims[e]);
            end
            for (int i = 0; i < lims[e] - 1; i++) pulse_t0();
            n_compared++;
            if (t0_n !== 1'b1) begin
                n_mismatch++;
                $display("FAIL spd_pre%0d: got %b expected 1", e, t0_n);
            end
            pulse_t0();
            n_compared++;
            if (t0_n !== 1'b0) begin
                n_mismatch++;
                $display("FAIL spd_exp%0d: got %b expected 0", e, t0_n);
            end
            pulse_t0();
            n_compared++;
            if (limit !== CW'(nexts[e]) || t0_n !== 1'b1) begin
                n_mismatch++;
                $display("FAIL spd_next%0d: got lim=%0d T0=%b expected lim=%0d T0=1", e, limit, t0_n, nexts[e]);
            end
        end
        do_clear();
        n_compared++;
        if (limit !== CW'(T0L)) begin
            n_mismatch++;
            $display("FAIL spd_clear_restore: got %0d expected %0d", limit, T0L);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_t0_expiry();
        test_independence();
        test_clear_priority();
        test_mid_reset();
`ifdef SC_TIMERBACKG_SPEEDUP_EN
        test_speedup();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
